jpeg_blk_writer: RTL
====================

# jpeg_blk_writer

Parametrised successor to the JPEG output frame-buffer writer. It takes the encoder's byte stream in 8x8 (generally BLK x BLK) block order and scatters it into a raster-ordered frame buffer. The write address is computed from block and pixel position, and partial blocks at the right and bottom edges are clipped. It adds a valid/ready handshake with memory back-pressure, explicit start/abort control and a frame-complete pulse. It sits between the encoder output and the frame-buffer write port.

## Interface
- WIDTH, 320, frame width in pixels
- HEIGHT, 200, frame height in pixels
- BPP, 2, bytes per pixel (1..4)
- BLK, 8, block edge in pixels (power of two, 2..16)
- ADDR_W, 17, address width; must hold BASE_ADDR + WIDTH*HEIGHT*BPP - 1
- BASE_ADDR, 0, frame-buffer base byte address
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame at pixel (0,0)
- abort  in  1  one-cycle pulse; terminates the frame immediately
- in_valid  in  1  encoder byte valid
- in_data  in  8  encoder byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- mem_ready  in  1  frame buffer can take a write next cycle
- addr  out  ADDR_W  write byte address
- data  out  8  write data
- we  out  1  write strobe, one cycle per byte
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse with the final write

## Operation
- States: IDLE, RUN.
  - IDLE -> RUN on start; all counters clear.
  - RUN -> IDLE on the final byte's acceptance, or on abort.
- in_ready = (state==RUN) && mem_ready. It is combinational and 0 in IDLE.
- Counters, all advancing on acceptance only:
  - byte_cnt: 0..BPP-1.
  - px, py: pixel within block.
  - bx, by: block origin, stepping by BLK.
- Column end: px==BLK-1 or bx+px==WIDTH-1.
- Row end: column end and (py==BLK-1 or by+py==HEIGHT-1).
- Advance order on the last byte of a pixel (byte_cnt==BPP-1):
  - Not column end: px++.
  - Column end, not row end: px=0, py++.
  - Row end, not last block column: bx+=BLK, px=py=0.
  - Row end, last block column: bx=0, by+=BLK, px=py=0.
  - Frame end: by+py==HEIGHT-1 and bx+px==WIDTH-1; go to IDLE.
- Address = BASE_ADDR + ((by+py)*WIDTH + (bx+px))*BPP + byte_cnt. Compute at ADDR_W bits; the multiply is truncated to ADDR_W bits.
- abort in RUN: go to IDLE next cycle. A byte accepted in the same cycle is still written. frame_done stays 0.
- abort takes priority over start. start in RUN restarts the frame at (0,0).
- Bytes offered in IDLE are not accepted; in_ready=0 holds the encoder.

## Timing
- Reset values: addr=0, data=0, we=0, busy=0, frame_done=0, in_ready=0, state=IDLE, all counters 0.
- One-cycle latency: a byte accepted at edge N has addr/data/we valid after edge N+1. we is high for exactly one cycle per accepted byte.
- The memory must accept any write whose source byte was accepted while mem_ready=1. No write is issued without a matching acceptance.
- frame_done is registered and coincident with the final byte's we.
- busy falls on the edge following the final acceptance or abort.
- Back-to-back acceptance sustains one byte per clock.
- Asserting reset_n low mid-frame clears everything asynchronously. A pending write is dropped.

## Configuration
- JPEG_BLK_WRITER_STATUS_EN defined:
  - Adds outputs byte_count[ADDR_W-1:0] and overflow.
  - byte_count clears on start and increments per accepted byte.
  - overflow is a sticky flag. It sets when in_valid=1 in IDLE within 16 cycles after frame end, meaning the encoder produced excess bytes. It clears on start.
- Not defined: both ports are absent and no counter logic is synthesised.

## Test plan
- Default parameters, start, 16 bytes 0x00..0x0F continuous with mem_ready=1 -> writes at addr 0..15 with matching data. Byte 17 -> addr 640, byte 129 -> addr 16 (block 1).
- Full 320x200 frame, 128000 bytes -> final write addr 127999, frame_done coincident, busy low after. No write to an address twice.
- WIDTH=12, HEIGHT=10, BPP=1, BLK=8 -> block(8,0) rows 4 bytes wide (addr 8..11, 20..23, ...). Block(0,8) is 2 rows (addr 96..103, 108..115). frame_done on addr 119 after 120 bytes.
- mem_ready toggling 1,0,0,1 with in_valid=1 -> in_ready tracks mem_ready, and the address sequence is identical to the unstalled run.
- abort after byte 50 -> byte 50 written, no further we, frame_done=0. A new start restarts at addr 0.
- STATUS_EN: after a full frame, byte_count=128000. One extra in_valid in IDLE -> overflow=1, cleared by the next start.

Source files
------------

// File: rtl/jpeg_blk_writer.sv
// Scatters a block-ordered encoder byte stream into a raster-ordered frame buffer.
// Optional status outputs (byte_count, overflow) are enabled by JPEG_BLK_WRITER_STATUS_EN.
module jpeg_blk_writer #(
  parameter int unsigned WIDTH     = 320,
  parameter int unsigned HEIGHT    = 200,
  parameter int unsigned BPP       = 2,
  parameter int unsigned BLK       = 8,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              we,
  output logic              busy,
  output logic              frame_done
`ifdef JPEG_BLK_WRITER_STATUS_EN
  ,
  output logic [ADDR_W-1:0] byte_count,
  output logic              overflow
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;
  typedef logic [15:0] cnt_t;

  localparam cnt_t       WLast   = cnt_t'(WIDTH - 1);
  localparam cnt_t       HLast   = cnt_t'(HEIGHT - 1);
  localparam cnt_t       BlkLast = cnt_t'(BLK - 1);
  localparam cnt_t       BlkStep = cnt_t'(BLK);
  localparam logic [1:0] BppLast = 2'(BPP - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  cnt_t        px_q, px_d, py_q, py_d, bx_q, bx_d, by_q, by_d;
  cnt_t        col, row;
  logic        accept, last_col, last_row, col_end, row_end, pix_last, frame_end;
  logic [ADDR_W-1:0] addr_calc;

  assign in_ready = (state_q == StRun) && mem_ready;
  assign busy     = (state_q == StRun);
  assign accept   = in_valid && in_ready;

  always_comb begin
    col       = bx_q + px_q;
    row       = by_q + py_q;
    last_col  = (col == WLast);
    last_row  = (row == HLast);
    col_end   = (px_q == BlkLast) || last_col;
    row_end   = col_end && ((py_q == BlkLast) || last_row);
    pix_last  = (byte_cnt_q == BppLast);
    frame_end = pix_last && last_col && last_row;
    addr_calc = ADDR_W'(BASE_ADDR)
              + (ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col)) * ADDR_W'(BPP)
              + ADDR_W'(byte_cnt_q);
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    px_d       = px_q;
    py_d       = py_q;
    bx_d       = bx_q;
    by_d       = by_q;
    if (abort) begin
      state_d = StIdle;
    end else if (start) begin
      state_d    = StRun;
      byte_cnt_d = '0;
      px_d       = '0;
      py_d       = '0;
      bx_d       = '0;
      by_d       = '0;
    end else if (accept) begin
      if (!pix_last) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end else begin
        byte_cnt_d = '0;
        if (frame_end) begin
          state_d = StIdle;
          px_d    = '0;
          py_d    = '0;
          bx_d    = '0;
          by_d    = '0;
        end else if (!col_end) begin
          px_d = px_q + cnt_t'(1);
        end else if (!row_end) begin
          px_d = '0;
          py_d = py_q + cnt_t'(1);
        end else if (!last_col) begin
          px_d = '0;
          py_d = '0;
          bx_d = bx_q + BlkStep;
        end else begin
          px_d = '0;
          py_d = '0;
          bx_d = '0;
          by_d = by_q + BlkStep;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      px_q       <= '0;
      py_q       <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      addr       <= '0;
      data       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      px_q       <= px_d;
      py_q       <= py_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      we         <= accept;
      // An aborted frame never reports completion, even on its final byte.
      frame_done <= accept && frame_end && !abort;
      if (accept) begin
        addr <= addr_calc;
        data <= in_data;
      end
    end
  end

`ifdef JPEG_BLK_WRITER_STATUS_EN
  logic [4:0] win_q;
  logic       start_eff;

  assign start_eff = start && !abort;

  // win_q counts down the post-frame window in which stray input means encoder overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q      <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (start_eff) begin
        win_q <= '0;
      end else if (accept && frame_end) begin
        win_q <= 5'd16;
      end else if ((state_q == StIdle) && (win_q != 5'd0)) begin
        win_q <= win_q - 5'd1;
      end
      if (start_eff) begin
        byte_count <= '0;
      end else if (accept) begin
        byte_count <= byte_count + ADDR_W'(1);
      end
      if (start_eff) begin
        overflow <= 1'b0;
      end else if ((state_q == StIdle) && in_valid && (win_q != 5'd0)) begin
        overflow <= 1'b1;
      end
    end
  end
`endif

endmodule
